// File: rtl/mpsoc_wb_fifo_ctrl_if.sv
// Push/pop and RAM-side signal bundle for the Wishbone UART FIFO controller.
// master: UART core, register file and RAM side; slave: the pointer/flag controller.
interface mpsoc_wb_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  clear;
    logic                  ovr_clr;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overrun;
    logic                  level_hit;
    logic [1:0]            trig_lvl;

    modport master (
        output push, push_data, pop, clear, ovr_clr, trig_lvl, ram_rdata,
        input  pop_data, ram_we, ram_waddr, ram_wdata, ram_raddr,
               count, empty, full, overrun, level_hit
    );

    modport slave (
        input  push, push_data, pop, clear, ovr_clr, trig_lvl, ram_rdata,
        output pop_data, ram_we, ram_waddr, ram_wdata, ram_raddr,
               count, empty, full, overrun, level_hit
    );
endinterface

// File: rtl/mpsoc_wb_fifo_ctrl.sv
// Circular-FIFO pointer/flag controller driving an external sync-write/async-read RAM.
// Optional level trigger output enabled by defining MPSOC_WB_FIFO_TRIGGER_EN.
module mpsoc_wb_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mpsoc_wb_fifo_ctrl_if.slave  bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  overrun;
    logic                  empty;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  push_drop;
    logic [DATA_WIDTH-1:0] wdata;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
    assign push_ok   = bus.push & (~full | bus.pop) & ~bus.clear;
    assign pop_ok    = bus.pop & ~empty & ~bus.clear;
    assign push_drop = bus.push & full & ~bus.pop & ~bus.clear;

    always_comb begin
        count_next = count;
        if (bus.clear)
            count_next = '0;
        else
            count_next = count + (ADDR_WIDTH + 1)'(push_ok) - (ADDR_WIDTH + 1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            count <= count_next;
            if (bus.clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                overrun <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(push_ok);
                rd_ptr <= rd_ptr + ADDR_WIDTH'(pop_ok);
                if (push_drop)
                    overrun <= 1'b1;
                else if (bus.ovr_clr)
                    overrun <= 1'b0;
            end
        end
    end

    assign wdata         = bus.push_data;
    assign bus.ram_wdata = wdata;
    // Write strobe is held off asynchronously while reset is asserted.
    assign bus.ram_we    = push_ok & rst_n;
    assign bus.ram_waddr = wr_ptr;
    assign bus.ram_raddr = rd_ptr;
    assign bus.pop_data  = bus.ram_rdata;
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overrun   = overrun;

`ifdef MPSOC_WB_FIFO_TRIGGER_EN
    function automatic logic [ADDR_WIDTH:0] trig_threshold(input logic [1:0] lvl);
        logic [ADDR_WIDTH:0] thr;
        case (lvl)
            2'b00:   thr = (ADDR_WIDTH + 1)'(1);
            2'b01:   thr = (ADDR_WIDTH + 1)'(DEPTH / 4);
            2'b10:   thr = (ADDR_WIDTH + 1)'(DEPTH / 2);
            default: thr = (ADDR_WIDTH + 1)'(DEPTH - 2);
        endcase
        return thr;
    endfunction

    logic level_hit;

    // Compared against the post-edge occupancy so the flag tracks count without lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_hit <= 1'b0;
        else if (bus.clear)
            level_hit <= 1'b0;
        else
            level_hit <= (count_next >= trig_threshold(bus.trig_lvl));
    end

    assign bus.level_hit = level_hit;
`else
    assign bus.level_hit = 1'b0;
`endif
endmodule

// File: tb/tb_mpsoc_wb_fifo_ctrl.sv
// Directed bench for mpsoc_wb_fifo_ctrl with a behavioural sync-write/async-read RAM.
module tb_mpsoc_wb_fifo_ctrl;
`ifdef MPSOC_WB_FIFO_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mpsoc_wb_fifo_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    mpsoc_wb_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [16];
    always @(posedge clk) if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    assign bus.ram_rdata = mem[bus.ram_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic ps, input logic [7:0] pd, input logic pp,
                          input logic clr, input logic oc);
        bus.push      = ps;
        bus.push_data = pd;
        bus.pop       = pp;
        bus.clear     = clr;
        bus.ovr_clr   = oc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.trig_lvl = 2'b10;
        set_in(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_level_hit", 32'(bus.level_hit), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_waddr", 32'(bus.ram_waddr), 32'd0);
        chk("rst_raddr", 32'(bus.ram_raddr), 32'd0);
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            #1;
            chk("fill_ram_we", 32'(bus.ram_we), 32'd1);
            chk("fill_waddr", 32'(bus.ram_waddr), 32'(i));
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_full", 32'(bus.full), 32'd1);
        chk("full_empty", 32'(bus.empty), 32'd0);
        chk("full_head", 32'(bus.pop_data), 32'h00);

        // push while full -> dropped, overrun
        set_in(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        #1;
        chk("drop_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        chk("drop_overrun", 32'(bus.overrun), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd16);
        set_in(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovr_set_prio", 32'(bus.overrun), 32'd1);
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovr_clr", 32'(bus.overrun), 32'd0);

        // full: push 0xAA + pop same cycle
        set_in(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fpp_pop_data", 32'(bus.pop_data), 32'h00);
        chk("fpp_ram_we", 32'(bus.ram_we), 32'd1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("fpp_count", 32'(bus.count), 32'd16);
        chk("fpp_overrun", 32'(bus.overrun), 32'd0);
        chk("fpp_raddr", 32'(bus.ram_raddr), 32'd1);
        chk("fpp_waddr", 32'(bus.ram_waddr), 32'd1);

        // drain: 0x01..0x0F then 0xAA
        for (int i = 0; i < 16; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            #1;
            chk("drain_data", 32'(bus.pop_data), (i < 15) ? 32'(i + 1) : 32'hAA);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pop_empty_count", 32'(bus.count), 32'd0);
        chk("pop_empty_raddr", 32'(bus.ram_raddr), 32'd1);
        chk("pop_empty_ovr", 32'(bus.overrun), 32'd0);

        // 20 interleaved push/pop, wrapping pointers
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
            #1;
            if (i > 0) chk("ilv_data", 32'(bus.pop_data), 32'(8'h30 + i - 1));
            tick();
            if (i == 0) chk("ilv_empty_pushpop", 32'(bus.count), 32'd1);
        end
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("ilv_last", 32'(bus.pop_data), 32'h43);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ilv_empty", 32'(bus.empty), 32'd1);
        chk("ilv_raddr", 32'(bus.ram_raddr), 32'd5);
        chk("ilv_waddr", 32'(bus.ram_waddr), 32'd5);

        // clear with simultaneous push+pop at count 7
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pre_clr_count", 32'(bus.count), 32'd7);
        set_in(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        #1;
        chk("clr_ram_we", 32'(bus.ram_we), 32'd0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_empty", 32'(bus.empty), 32'd1);
        chk("clr_waddr", 32'(bus.ram_waddr), 32'd0);
        chk("clr_raddr", 32'(bus.ram_raddr), 32'd0);

        // level trigger at DEPTH/2
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("lvl_at7", 32'(bus.level_hit), 32'd0);
        set_in(1'b1, 8'h87, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lvl_count8", 32'(bus.count), 32'd8);
        chk("lvl_at8", 32'(bus.level_hit), 32'(TRIG_EN));
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lvl_back7", 32'(bus.level_hit), 32'd0);
        chk("lvl_count7", 32'(bus.count), 32'd7);

        // asynchronous reset mid-burst
        set_in(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("arst_overrun", 32'(bus.overrun), 32'd0);
        chk("arst_level_hit", 32'(bus.level_hit), 32'd0);
        chk("arst_waddr", 32'(bus.ram_waddr), 32'd0);
        set_in(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        chk("post_rst_data", 32'(bus.pop_data), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mpsoc_wb_fifo_ctrl.md
Name: mpsoc_wb_fifo_ctrl

Overview:
Pointer/flag controller that sequences an external dual-port RAM (sync write, async read) as a circular FIFO for the UART TX/RX paths on the Wishbone side. It owns the write/read pointers, occupancy count, full/empty/overrun flags and the RAM write strobe. It presents a push/pop interface to the UART core and register file.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, entry width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  write request
push_data  in  DATA_WIDTH  data to write
pop  in  1  read request
pop_data  out  DATA_WIDTH  head entry; equals ram_rdata
clear  in  1  synchronous flush (FCR reset bit)
ovr_clr  in  1  clears sticky overrun (LSR read)
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_WIDTH  RAM write address (= wr_ptr)
ram_wdata  out  DATA_WIDTH  RAM write data (= push_data)
ram_raddr  out  ADDR_WIDTH  RAM async read address (= rd_ptr)
ram_rdata  in  DATA_WIDTH  RAM async read data
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overrun  out  1  sticky: push dropped while full
level_hit  out  1  see Optional Feature
trig_lvl  in  2  see Optional Feature

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, overrun=0; hence empty=1, full=0, level_hit=0; ram_we forced 0 while rst_n low. RAM contents not touched.
- push_ok = push & (!full | pop) & !clear; pop_ok = pop & !empty & !clear.
- ram_we = push_ok, combinational, same cycle as push; entry written at wr_ptr on that edge.
- pop_data combinational from ram_rdata at rd_ptr; valid whenever !empty; zero-latency read (show-ahead). Consumer samples pop_data in the cycle it asserts pop.
- Edge update: wr_ptr += push_ok; rd_ptr += pop_ok; count += push_ok - pop_ok. Pointers wrap modulo DEPTH naturally (ADDR_WIDTH bits).
- Write latency: data pushed in cycle N visible on pop_data in cycle N+1 (empty deasserts at N+1).
- Full + push + pop same cycle: both accepted, count stays DEPTH, no overrun; old head read before overwrite of the same slot is not possible (wr_ptr==rd_ptr only when head already popped this cycle; async read returns pre-edge value).
- Empty + push + pop same cycle: push accepted, pop ignored (no bypass); count becomes 1.
- Pop while empty: ignored, no flag, pointers unchanged.
- Push while full without pop: dropped, ram_we=0, overrun set next edge.
- overrun: set by dropped push; cleared by ovr_clr or clear or reset; set has priority over ovr_clr in same cycle.
- clear: highest priority; next edge wr_ptr=rd_ptr=count=0, overrun=0; push/pop in that cycle discarded, ram_we=0.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
Macro MPSOC_WB_FIFO_TRIGGER_EN. Defined: level_hit registered, = (count_next >= threshold), threshold from trig_lvl: 00->1, 01->DEPTH/4, 10->DEPTH/2, 11->DEPTH-2 (1/4/8/14 at DEPTH 16); cleared by reset and clear. Not defined: level_hit tied 0, trig_lvl ignored.

Test Plan:
Reset then 16 pushes 0x00..0x0F, no pops -> count=16, full=1 after 16th edge, ram_we high each push cycle, ram_waddr 0..15.
17th push while full -> ram_we=0, overrun=1 next cycle, count=16; ovr_clr pulse -> overrun=0.
Full, push 0xAA + pop same cycle -> pop_data=0x00, count=16, overrun=0, wr_ptr/rd_ptr both advance.
Push 20, pop 20 interleaved -> pointers wrap 15->0, popped sequence matches pushed order, empty=1 at end.
Count=7, assert clear with push+pop -> next cycle count=0, empty=1, ram_we=0 during clear; pull rst_n low mid-burst -> flags reset asynchronously.
With MPSOC_WB_FIFO_TRIGGER_EN, trig_lvl=10 -> level_hit rises the cycle count reaches 8, falls when count drops to 7.
